// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and constants for the CPU-side memory bus controller
//
// Contents:
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths (16x8 memory)
//   state_t                 : bus transaction sequencer states
//   RW_READ / RW_WRITE      : read_write pin encoding
//   gnt_t                   : arbiter grant encoding, doubles as the grant-vector bit index
package cpu_mem_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_rr_arb.sv
// rtl/mem_rr_arb.sv - two-port round-robin arbiter (fetch vs data)
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req[1:0]    : request vector, bit GNT_FETCH = fetch, bit GNT_DATA = data
//   update      : allow last_grant to move when something is granted
//   grant[1:0]  : combinational one-hot grant (zero when nothing requested)
//   last_grant  : port granted most recently; resets to GNT_DATA so fetch wins the first tie
module mem_rr_arb
  import cpu_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant,
  output gnt_t       last_grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Tie: favour whichever port did not win last time.
      2'b11:   grant = (last_grant == GNT_DATA) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_DATA;
    end else if (update && (|req)) begin
      last_grant <= grant[1] ? GNT_DATA : GNT_FETCH;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - arbitrated fetch/data controller for a 16x8 memory with a shared tristate data bus
//
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   f_req, f_addr                   : fetch request (read-only), level held until f_ack
//   f_ack, f_rdata                  : one-cycle fetch completion pulse, fetched byte (held)
//   d_req, d_we, d_addr, d_wdata    : data load/store request, level held until d_ack
//   d_ack, d_rdata                  : one-cycle data completion pulse, load result (held)
//   address_bus, mem_enable,
//   read_write                      : registered memory controls (read_write 1 = read)
//   data_bus                        : shared bus, driven only during the WR cycle
module mem_bus_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] address_bus,
  output logic              mem_enable,
  output logic              read_write,
  inout  wire  [DATA_W-1:0] data_bus
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        arb_req;
  logic [1:0]        arb_grant;
  gnt_t              last_grant;
  logic              win_fetch;
  logic              win_write;
  logic              bus_oe;
  logic [DATA_W-1:0] wdata_q;

  assign arb_req = {d_req, f_req};

  // last_grant only moves on a grant taken in IDLE, so for the rest of the
  // transaction it names the port being served; no separate owner flop needed.
  mem_rr_arb u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (arb_req),
    .update     (state == IDLE),
    .grant      (arb_grant),
    .last_grant (last_grant)
  );

  assign win_fetch = arb_grant[0];
  // Fetch is read-only: d_we only matters when the data port wins.
  assign win_write = arb_grant[1] & d_we;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (|arb_req) begin
          state_nxt = win_write ? WR : RD_ADDR;
        end
      end
      RD_ADDR: state_nxt = RD_DATA;
      RD_DATA: state_nxt = RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side pins and acks are decoded from state_nxt so every output is a
  // flop that lines up exactly with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      address_bus <= '0;
      mem_enable  <= 1'b0;
      read_write  <= RW_READ;
      bus_oe      <= 1'b0;
      wdata_q     <= '0;
      f_ack       <= 1'b0;
      d_ack       <= 1'b0;
      f_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      state      <= state_nxt;
      mem_enable <= (state_nxt == RD_ADDR) || (state_nxt == RD_DATA) || (state_nxt == WR);
      read_write <= (state_nxt == WR) ? RW_WRITE : RW_READ;
      bus_oe     <= (state_nxt == WR);
      f_ack      <= (state_nxt == RESP) && (last_grant == GNT_FETCH);
      d_ack      <= (state_nxt == RESP) && (last_grant == GNT_DATA);

      if ((state == IDLE) && (|arb_req)) begin
        address_bus <= win_fetch ? f_addr : d_addr;
        if (!win_fetch) begin
          wdata_q <= d_wdata;
        end
      end

      // The memory drives data_bus throughout RD_DATA; capture at its end.
      if (state == RD_DATA) begin
        if (last_grant == GNT_FETCH) begin
          f_rdata <= data_bus;
        end else begin
          d_rdata <= data_bus;
        end
      end
    end
  end

  assign data_bus = bus_oe ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - self-checking bench for mem_bus_ctrl with a 16x8 memory model
module tb_mem_bus_ctrl;

  logic       clk;
  logic       rst_n;
  logic       f_req;
  logic [3:0] f_addr;
  logic       d_req;
  logic       d_we;
  logic [3:0] d_addr;
  logic [7:0] d_wdata;
  wire        f_ack;
  wire  [7:0] f_rdata;
  wire        d_ack;
  wire  [7:0] d_rdata;
  wire  [3:0] address_bus;
  wire        mem_enable;
  wire        read_write;
  // Released bus reads as 8'hFF through the pull-up.
  tri1  [7:0] data_bus;

  int n_tests;
  int n_fail;

  mem_bus_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .f_req       (f_req),
    .f_addr      (f_addr),
    .f_ack       (f_ack),
    .f_rdata     (f_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .d_rdata     (d_rdata),
    .address_bus (address_bus),
    .mem_enable  (mem_enable),
    .read_write  (read_write),
    .data_bus    (data_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: samples address at the edge ending the first enabled read
  // cycle, drives data for the following cycle, writes at the end of a write cycle.
  logic [7:0] mem [16];
  logic       mem_drv;
  logic [7:0] mem_dout;

  function automatic logic [7:0] init_val(input int i);
    return (i == 5) ? 8'h0F : 8'(8'h30 + i);
  endfunction

  assign data_bus = (mem_drv && mem_enable && read_write) ? mem_dout : 8'hzz;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
      mem_drv  <= 1'b0;
      mem_dout <= 8'h00;
    end else begin
      mem_drv  <= mem_enable && read_write && !mem_drv;
      mem_dout <= mem[address_bus];
      if (mem_enable && !read_write) mem[address_bus] <= data_bus;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_en"},   32'(mem_enable),  32'h0);
    chk({tag, "_rw"},   32'(read_write),  32'h1);
    chk({tag, "_bus"},  32'(data_bus),    32'hFF);
    chk({tag, "_fack"}, 32'(f_ack),       32'h0);
    chk({tag, "_dack"}, 32'(d_ack),       32'h0);
  endtask

  typedef struct {
    logic       f_req;
    logic [3:0] f_addr;
    logic       d_req;
    logic       d_we;
    logic [3:0] d_addr;
    logic [7:0] d_wdata;
    logic       en;
    logic       rw;
    logic [3:0] addr;
    logic [7:0] bus;
    logic       fa;
    logic       da;
    logic [7:0] frd;
    logic [7:0] drd;
  } vec_t;

  vec_t vt[11];
  logic got;
  int   lat;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    f_req   = 1'b0;
    f_addr  = 4'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 4'h0;
    d_wdata = 8'h00;

    // Fetch mem[5], write 0x5C to 0xA, read it back; one row per clock edge.
    //          freq fa  dreq we da    wd     en rw addr bus    fa da frd    drd
    vt[0]  = '{1, 4'h5, 0, 0, 4'h0, 8'h00, 1, 1, 4'h5, 8'hFF, 0, 0, 8'h00, 8'h00};
    vt[1]  = '{1, 4'h5, 0, 0, 4'h0, 8'h00, 1, 1, 4'h5, 8'h0F, 0, 0, 8'h00, 8'h00};
    vt[2]  = '{1, 4'h5, 0, 0, 4'h0, 8'h00, 0, 1, 4'h5, 8'hFF, 1, 0, 8'h0F, 8'h00};
    vt[3]  = '{0, 4'h0, 0, 0, 4'h0, 8'h00, 0, 1, 4'h5, 8'hFF, 0, 0, 8'h0F, 8'h00};
    vt[4]  = '{0, 4'h0, 1, 1, 4'hA, 8'h5C, 1, 0, 4'hA, 8'h5C, 0, 0, 8'h0F, 8'h00};
    vt[5]  = '{0, 4'h0, 1, 1, 4'hA, 8'h5C, 0, 1, 4'hA, 8'hFF, 0, 1, 8'h0F, 8'h00};
    vt[6]  = '{0, 4'h0, 0, 0, 4'h0, 8'h00, 0, 1, 4'hA, 8'hFF, 0, 0, 8'h0F, 8'h00};
    vt[7]  = '{0, 4'h0, 1, 0, 4'hA, 8'h00, 1, 1, 4'hA, 8'hFF, 0, 0, 8'h0F, 8'h00};
    vt[8]  = '{0, 4'h0, 1, 0, 4'hA, 8'h00, 1, 1, 4'hA, 8'h5C, 0, 0, 8'h0F, 8'h00};
    vt[9]  = '{0, 4'h0, 1, 0, 4'hA, 8'h00, 0, 1, 4'hA, 8'hFF, 0, 1, 8'h0F, 8'h5C};
    vt[10] = '{0, 4'h0, 0, 0, 4'h0, 8'h00, 0, 1, 4'hA, 8'hFF, 0, 0, 8'h0F, 8'h5C};

    // Reset, released mid-cycle.
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk_idle_outputs("rst");
    chk("rst_addr",  32'(address_bus), 32'h0);
    chk("rst_frd",   32'(f_rdata),     32'h0);
    chk("rst_drd",   32'(d_rdata),     32'h0);

    for (int k = 0; k < 11; k++) begin
      f_req   = vt[k].f_req;
      f_addr  = vt[k].f_addr;
      d_req   = vt[k].d_req;
      d_we    = vt[k].d_we;
      d_addr  = vt[k].d_addr;
      d_wdata = vt[k].d_wdata;
      tick();
      chk($sformatf("row%0d_en", k),   32'(mem_enable),  32'(vt[k].en));
      chk($sformatf("row%0d_rw", k),   32'(read_write),  32'(vt[k].rw));
      chk($sformatf("row%0d_addr", k), 32'(address_bus), 32'(vt[k].addr));
      chk($sformatf("row%0d_bus", k),  32'(data_bus),    32'(vt[k].bus));
      chk($sformatf("row%0d_fack", k), 32'(f_ack),       32'(vt[k].fa));
      chk($sformatf("row%0d_dack", k), 32'(d_ack),       32'(vt[k].da));
      chk($sformatf("row%0d_frd", k),  32'(f_rdata),     32'(vt[k].frd));
      chk($sformatf("row%0d_drd", k),  32'(d_rdata),     32'(vt[k].drd));
    end

    // Both ports held after reset: fetch wins first, then strict alternation.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    f_req  = 1'b1;
    f_addr = 4'h2;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 4'h9;
    for (int c = 1; c <= 16; c++) begin
      int  ph;
      bit  fetch_turn;
      tick();
      ph         = (c - 1) % 4;
      fetch_turn = (((c - 1) / 4) % 2) == 0;
      chk($sformatf("rr%0d_en", c),   32'(mem_enable), 32'(ph < 2));
      chk($sformatf("rr%0d_fack", c), 32'(f_ack),      32'(ph == 2 && fetch_turn));
      chk($sformatf("rr%0d_dack", c), 32'(d_ack),      32'(ph == 2 && !fetch_turn));
      chk($sformatf("rr%0d_addr", c), 32'(address_bus), fetch_turn ? 32'h2 : 32'h9);
      if (ph >= 2) chk($sformatf("rr%0d_bus", c), 32'(data_bus), 32'hFF);
      if (ph == 2 && fetch_turn)  chk($sformatf("rr%0d_frd", c), 32'(f_rdata), 32'h32);
      if (ph == 2 && !fetch_turn) chk($sformatf("rr%0d_drd", c), 32'(d_rdata), 32'h39);
    end
    f_req = 1'b0;
    d_req = 1'b0;
    tick();

    // Asynchronous reset during RD_DATA aborts the read.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 4'h3;
    tick();
    tick();
    chk("abort_in_rd_data_en", 32'(mem_enable), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("abort_async");
    chk("abort_async_addr", 32'(address_bus), 32'h0);
    chk("abort_async_frd",  32'(f_rdata),     32'h0);
    chk("abort_async_drd",  32'(d_rdata),     32'h0);
    d_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("abort_hold%0d_dack", c), 32'(d_ack), 32'h0);
    end
    #3 rst_n = 1'b1;
    tick();
    chk_idle_outputs("abort_rel");

    d_req = 1'b1;
    got   = 1'b0;
    lat   = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (d_ack) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    chk("reissue_ack",   32'(got), 32'h1);
    chk("reissue_lat",   32'(lat), 32'h2);
    chk("reissue_drd",   32'(d_rdata), 32'h33);
    d_req = 1'b0;
    tick();

    // Write request held through its ack repeats the identical write.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 4'h7;
    d_wdata = 8'h42;
    for (int c = 1; c <= 6; c++) begin
      int ph;
      tick();
      ph = (c - 1) % 3;
      chk($sformatf("hold%0d_en", c),   32'(mem_enable), 32'(ph == 0));
      chk($sformatf("hold%0d_rw", c),   32'(read_write), 32'(ph != 0));
      chk($sformatf("hold%0d_bus", c),  32'(data_bus),   (ph == 0) ? 32'h42 : 32'hFF);
      chk($sformatf("hold%0d_dack", c), 32'(d_ack),      32'(ph == 1));
    end
    d_req = 1'b0;
    tick();
    chk_idle_outputs("hold_end");
    chk("hold_mem7", 32'(mem[7]), 32'h42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
